aib_tx_packer: RTL and testbench

Link-layer packer that sits directly upstream of the AIB channel Tx datapath. It accepts a 32-bit word stream with end-of-packet marking and packs word pairs into 72-bit flits. Each flit carries a word-valid mask, a last flag, a 4-bit sequence number and even parity. It drives the channel's `i_tx_valid`/`o_tx_ready`/`i_tx_data` ready/valid interface and flushes lone words after a programmable idle timeout.

---
 rtl/aib_tx_packer.sv | 109 ++++++++++
 tb/tb_aib_tx_packer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aib_tx_packer.sv
// aib_tx_packer: packs a 32-bit word stream into 72-bit AIB Tx flits.
// Word pairs share a flit; a lone word is flushed as a half flit after an idle timeout.
module aib_tx_packer #(
  parameter int unsigned FLUSH_TIMEOUT = 16
) (
  input  logic        i_aib_clk,
  input  logic        i_rst,
  input  logic        i_word_valid,
  output logic        o_word_ready,
  input  logic [31:0] i_word_data,
  input  logic        i_word_last,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic [71:0] o_tx_data
);

  localparam int TW =
    (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] T_MAX  = TW'(FLUSH_TIMEOUT);
  localparam logic [TW-1:0] T_FIRE = TW'(FLUSH_TIMEOUT - 1);

  typedef enum logic {
    EMPTY,
    HALF
  } state_t;

  state_t        state;
  logic [31:0]   hold;
  logic [3:0]    seq;
  logic [TW-1:0] timer;

  logic          out_free;
  logic          accept;
  logic          flush_due;
  logic          emit;
  logic [66:0]   emit_lo;
  logic [70:0]   body;

  assign out_free     = !o_tx_valid || i_tx_ready;
  assign o_word_ready = out_free && !i_rst;
  assign accept       = i_word_valid && o_word_ready;

  // Fires on the last idle cycle, or later once saturated and the slot frees.
  assign flush_due = (FLUSH_TIMEOUT != 0)
                  && (state == HALF)
                  && !accept
                  && out_free
                  && ((timer == T_FIRE) || (timer == T_MAX));

  always_comb begin
    emit    = 1'b0;
    emit_lo = '0;
    unique case (1'b1)
      (accept && state == EMPTY && i_word_last): begin
        emit    = 1'b1;
        emit_lo = {1'b1, 2'b01, 32'h0, i_word_data};
      end
      (accept && state == HALF): begin
        emit    = 1'b1;
        emit_lo = {i_word_last, 2'b11, i_word_data, hold};
      end
      flush_due: begin
        emit    = 1'b1;
        emit_lo = {1'b0, 2'b01, 32'h0, hold};
      end
      default: ;
    endcase
  end

  assign body = {seq, emit_lo};

  always_ff @(posedge i_aib_clk) begin
    if (i_rst) begin
      o_tx_valid <= 1'b0;
      o_tx_data  <= '0;
      state      <= EMPTY;
      seq        <= '0;
      timer      <= '0;
      hold       <= '0;
    end else begin
      if (emit) begin
        o_tx_data  <= {^body, body};
        o_tx_valid <= 1'b1;
        seq        <= seq + 4'd1;
      end else if (out_free) begin
        o_tx_valid <= 1'b0;
      end
      unique case (state)
        EMPTY: begin
          if (accept && !i_word_last) begin
            hold  <= i_word_data;
            state <= HALF;
            timer <= '0;
          end
        end
        HALF: begin
          if (accept || flush_due) begin
            state <= EMPTY;
            timer <= '0;
          end else if (timer != T_MAX) begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_aib_tx_packer.sv
// tb_aib_tx_packer: table vectors plus scoreboard sequences
// for pair packing, flush timeout, backpressure, seq wrap and reset.
module tb_aib_tx_packer;

  localparam int FT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        word_valid = 1'b0;
  logic        word_ready;
  logic [31:0] word_data = '0;
  logic        word_last = 1'b0;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [71:0] tx_data;

  int          checks = 0;
  int          errors = 0;
  int          mon_count = 0;
  logic [71:0] q[$];
  logic [71:0] mon_exp;
  logic [71:0] held;
  logic [3:0]  m_seq = '0;
  logic        m_half = 1'b0;
  logic [31:0] m_hold = '0;
  int          wrap_start;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        has;
    logic [66:0] lo;
  } vec_t;

  vec_t vt[6];

  aib_tx_packer #(.FLUSH_TIMEOUT(FT)) dut (
    .i_aib_clk    (clk),
    .i_rst        (rst),
    .i_word_valid (word_valid),
    .o_word_ready (word_ready),
    .i_word_data  (word_data),
    .i_word_last  (word_last),
    .o_tx_valid   (tx_valid),
    .i_tx_ready   (tx_ready),
    .o_tx_data    (tx_data)
  );

  always #5 clk = ~clk;

  function automatic logic [71:0] mk(
    input logic [66:0] lo,
    input logic [3:0]  s
  );
    logic [70:0] b;
    b = {s, lo};
    return {^b, b};
  endfunction

  task automatic chk(input string name,
                     input logic [71:0] act,
                     input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name,
                      input logic act,
                      input logic exp);
    chk(name, 72'(act), 72'(exp));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    word_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic model_accept(input logic [31:0] d,
                              input logic l);
    if (!m_half) begin
      if (l) begin
        q.push_back(mk({1'b1, 2'b01, 32'h0, d}, m_seq));
        m_seq = m_seq + 4'd1;
      end else begin
        m_hold = d;
        m_half = 1'b1;
      end
    end else begin
      q.push_back(mk({l, 2'b11, d, m_hold}, m_seq));
      m_seq  = m_seq + 4'd1;
      m_half = 1'b0;
    end
  endtask

  task automatic send(input logic [31:0] d,
                      input logic l,
                      input bit use_model);
    bit ok;
    ok         = 1'b0;
    word_valid = 1'b1;
    word_data  = d;
    word_last  = l;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (word_ready) begin
        ok = 1'b1;
        if (use_model) model_accept(d, l);
      end
      step();
    end
    chk1("send_accept", ok, 1'b1);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    word_valid = 1'b0;
    @(negedge clk);
    chk1("rst_word_ready", word_ready, 1'b0);
    step();
    @(negedge clk);
    chk1("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 72'h0);
    step();
    rst    = 1'b0;
    m_seq  = '0;
    m_half = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) step();
    chk1("sb_drained", q.size() == 0, 1'b1);
  endtask

  always @(negedge clk) begin
    if (!rst && tx_valid === 1'b1 && tx_ready) begin
      mon_count++;
      chk1("parity", ^tx_data, 1'b0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_flit act=%h exp=none", tx_data);
      end else begin
        mon_exp = q.pop_front();
        chk("flit", tx_data, mon_exp);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{32'h11111111, 1'b0, 1'b0, 67'h0};
    vt[1] = '{32'h22222222, 1'b1, 1'b1,
              {1'b1, 2'b11, 32'h22222222, 32'h11111111}};
    vt[2] = '{32'hDEADBEEF, 1'b1, 1'b1,
              {1'b1, 2'b01, 32'h0, 32'hDEADBEEF}};
    vt[3] = '{32'hCAFEF00D, 1'b0, 1'b0, 67'h0};
    vt[4] = '{32'h12345678, 1'b0, 1'b1,
              {1'b0, 2'b11, 32'h12345678, 32'hCAFEF00D}};
    vt[5] = '{32'hFFFFFFFF, 1'b1, 1'b1,
              {1'b1, 2'b01, 32'h0, 32'hFFFFFFFF}};

    do_reset();

    foreach (vt[i]) begin
      send(vt[i].data, vt[i].last, 1'b0);
      word_valid = 1'b0;
      if (vt[i].has) begin
        q.push_back(mk(vt[i].lo, m_seq));
        m_seq = m_seq + 4'd1;
      end
      @(negedge clk);
      chk1("lat_valid", tx_valid, vt[i].has);
      if (vt[i].has) chk("lat_data", 72'(tx_data[66:0]), 72'(vt[i].lo));
      step();
    end

    idle(3);
    send(32'hA5A5A5A5, 1'b0, 1'b0);
    word_valid = 1'b0;
    q.push_back(mk({1'b0, 2'b01, 32'h0, 32'hA5A5A5A5}, m_seq));
    m_seq = m_seq + 4'd1;
    for (int k = 1; k <= FT + 1; k++) begin
      @(negedge clk);
      chk1($sformatf("flush_t%0d", k), tx_valid, k == FT + 1);
      step();
    end
    send(32'h0BADF00D, 1'b1, 1'b1);
    word_valid = 1'b0;
    @(negedge clk);
    chk1("post_flush_valid", tx_valid, 1'b1);
    chk("post_flush_mask", 72'(tx_data[65:64]), 72'(2'b01));
    step();

    idle(2);
    fork
      begin
        for (int i = 0; i < 20; i++)
          send(32'h10000000 + 32'(i), i == 19, 1'b1);
        word_valid = 1'b0;
      end
      begin
        step();
        step();
        tx_ready = 1'b0;
        held     = tx_data;
        for (int j = 0; j < 5; j++) begin
          @(negedge clk);
          chk1("bp_valid", tx_valid, 1'b1);
          chk1("bp_word_ready", word_ready, 1'b0);
          chk("bp_stable", tx_data, held);
        end
        step();
        tx_ready = 1'b1;
      end
    join
    wait_drain();

    do_reset();
    wrap_start = mon_count;
    for (int i = 0; i < 34; i++)
      send(32'h50000000 + 32'(i), i[0], 1'b1);
    word_valid = 1'b0;
    wait_drain();
    chk("wrap_flits", 72'(mon_count - wrap_start), 72'd17);

    tx_ready = 1'b0;
    send(32'h77777777, 1'b1, 1'b0);
    word_valid = 1'b0;
    @(negedge clk);
    chk1("pend_valid", tx_valid, 1'b1);
    step();
    do_reset();
    tx_ready = 1'b1;
    send(32'h88888888, 1'b0, 1'b0);
    word_valid = 1'b0;
    do_reset();
    send(32'h99999999, 1'b1, 1'b1);
    word_valid = 1'b0;
    @(negedge clk);
    chk("rst_seq0", 72'(tx_data[70:67]), 72'h0);
    chk("rst_no_stale", 72'(tx_data[63:32]), 72'h0);
    step();
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
